// File: rtl/adc_channel_sequencer_if.sv
// ADC controller handshake bundle: the sequencer drives go/channel, the ADC
// controller returns a done level and the conversion result.
interface adc_channel_sequencer_if #(
    parameter int CH_NUM = 8,
    parameter int DATA_W = 12
);
    localparam int CH_W = $clog2(CH_NUM);

    logic              adc_go_o;
    logic [CH_W-1:0]   adc_ch_o;
    logic              adc_done_i;
    logic [DATA_W-1:0] adc_data_i;

    modport master (
        output adc_go_o,
        output adc_ch_o,
        input  adc_done_i,
        input  adc_data_i
    );

    modport slave (
        input  adc_go_o,
        input  adc_ch_o,
        output adc_done_i,
        output adc_data_i
    );
endinterface

// File: rtl/adc_channel_sequencer.sv
// Sweeps enabled ADC channels once per sample tick and emits channel-tagged samples.
// Optional per-channel conversion timeout: define ADC_SEQ_TIMEOUT_EN.
module adc_channel_sequencer #(
    parameter int CLK_FRQ     = 50000000,
    parameter int SAMP_FRQ    = 12500,
    parameter int CH_NUM      = 8,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CH_W       = $clog2(CH_NUM)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CH_NUM-1:0]      ch_en_i,
    adc_channel_sequencer_if.master adc,
    output logic [DATA_W-1:0]      smp_data_o,
    output logic [CH_W-1:0]        smp_ch_o,
    output logic                   smp_val_o,
    output logic                   sweep_done_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);
    localparam int TICK_CNT = CLK_FRQ / SAMP_FRQ;
    localparam int TCK_W    = $clog2(TICK_CNT);

    if (TICK_CNT < 2 || CH_NUM < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("adc_channel_sequencer: TICK_CNT, CH_NUM and TIMEOUT_CYC must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

    state_t              r_state, w_state_n;
    logic [TCK_W-1:0]    r_tick_cnt;
    logic                w_tick;
    logic [CH_NUM-1:0]   r_mask, w_mask_n;
    logic [CH_W-1:0]     r_ch, w_ch_n;
    logic                r_go, w_go_n;
    logic [DATA_W-1:0]   r_smp_data, w_smp_data_n;
    logic [CH_W-1:0]     r_smp_ch, w_smp_ch_n;
    logic                r_smp_val, w_smp_val_n;
    logic                r_sweep_done, w_sweep_done_n;
    logic                r_overrun, w_overrun_n;
    logic                r_timeout, w_timeout_n;
    logic [CH_W-1:0]     w_first_ch, w_next_ch;
    logic                w_has_next;

    assign w_tick = (r_tick_cnt == TCK_W'(TICK_CNT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) r_tick_cnt <= '0;
        else       r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end

    // Downward scans leave the lowest qualifying index as the final assignment.
    always_comb begin
        w_first_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (ch_en_i[i]) w_first_ch = CH_W'(i);
    end

    always_comb begin
        w_has_next = 1'b0;
        w_next_ch  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (r_mask[i] && (CH_W'(i) > r_ch)) begin
                w_has_next = 1'b1;
                w_next_ch  = CH_W'(i);
            end
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_n;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_to_cnt <= '0;
        else       r_to_cnt <= w_to_cnt_n;
    end
`endif

    always_comb begin
        w_state_n      = r_state;
        w_mask_n       = r_mask;
        w_ch_n         = r_ch;
        w_go_n         = r_go;
        w_smp_data_n   = r_smp_data;
        w_smp_ch_n     = r_smp_ch;
        w_smp_val_n    = 1'b0;
        w_sweep_done_n = 1'b0;
        w_overrun_n    = w_tick && (r_state != IDLE);
        w_timeout_n    = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
        w_to_cnt_n     = r_to_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_tick && (|ch_en_i)) begin
                    w_mask_n  = ch_en_i;
                    w_ch_n    = w_first_ch;
                    w_state_n = START;
                end
            end
            START: begin
                w_go_n    = 1'b1;
                w_state_n = WAIT_DONE;
`ifdef ADC_SEQ_TIMEOUT_EN
                w_to_cnt_n = '0;
`endif
            end
            WAIT_DONE: begin
                if (adc.adc_done_i) begin
                    w_go_n       = 1'b0;
                    w_smp_val_n  = 1'b1;
                    w_smp_data_n = adc.adc_data_i;
                    w_smp_ch_n   = r_ch;
                    w_state_n    = RELEASE;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_go_n      = 1'b0;
                    w_timeout_n = 1'b1;
                    w_state_n   = RELEASE;
                end else begin
                    w_to_cnt_n = r_to_cnt + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!adc.adc_done_i) begin
                    if (w_has_next) begin
                        w_ch_n    = w_next_ch;
                        w_state_n = START;
                    end else begin
                        w_sweep_done_n = 1'b1;
                        w_state_n      = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_ch         <= '0;
            r_go         <= 1'b0;
            r_smp_data   <= '0;
            r_smp_ch     <= '0;
            r_smp_val    <= 1'b0;
            r_sweep_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_mask       <= w_mask_n;
            r_ch         <= w_ch_n;
            r_go         <= w_go_n;
            r_smp_data   <= w_smp_data_n;
            r_smp_ch     <= w_smp_ch_n;
            r_smp_val    <= w_smp_val_n;
            r_sweep_done <= w_sweep_done_n;
            r_overrun    <= w_overrun_n;
            r_timeout    <= w_timeout_n;
        end
    end

    assign adc.adc_go_o = r_go;
    assign adc.adc_ch_o = r_ch;
    assign smp_data_o   = r_smp_data;
    assign smp_ch_o     = r_smp_ch;
    assign smp_val_o    = r_smp_val;
    assign sweep_done_o = r_sweep_done;
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;
endmodule
